// File: rtl/av1_pred_pkg.sv
// Shared types and constants for the AV1 DC intra predictor.
// Sample widths here follow the default 10-bit, 3-component pixel format.
package av1_pred_pkg;

    localparam int PKG_BIT_DEPTH = 10;
    localparam int PKG_NUM_CH    = 3;

    typedef logic [PKG_BIT_DEPTH-1:0]            chan_t;
    typedef logic [PKG_NUM_CH*PKG_BIT_DEPTH-1:0] pixel_t;

    // Q16 reciprocals of 3 and 5: rectangular blocks average over (w+h)/min = 3 or 5 sides.
    localparam logic [15:0] RECIP_R2 = 16'h5556;
    localparam logic [15:0] RECIP_R4 = 16'h3334;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC_ABOVE,
        ST_ACC_LEFT,
        ST_CALC,
        ST_EMIT
    } dc_state_e;

    typedef enum logic [1:0] {
        DC_NONE,
        DC_LEFT,
        DC_ABOVE,
        DC_BOTH
    } dc_mode_e;

endpackage

// File: rtl/dc_norm.sv
// One channel's combinational sum-to-DC normalisation: round, shift,
// reciprocal multiply for rectangular blocks, saturate.
module dc_norm
    import av1_pred_pkg::*;
#(
    parameter int BIT_DEPTH = 10,
    parameter int MAX_LOG2  = 4,
    parameter int SUM_W     = BIT_DEPTH + MAX_LOG2 + 1
) (
    input  logic [SUM_W-1:0]     sum,
    input  logic [2:0]           log2w,
    input  logic [2:0]           log2h,
    input  dc_mode_e             mode,
    output logic [BIT_DEPTH-1:0] dc
);

    localparam int EXT_W  = SUM_W + 1;
    localparam int PROD_W = EXT_W + 16;
    localparam logic [EXT_W-1:0] DC_MAX = EXT_W'((1 << BIT_DEPTH) - 1);

    logic [EXT_W-1:0]  w, h, rnd, acc, s, dc_raw;
    logic [2:0]        shamt, lmin, diff;
    logic [PROD_W-1:0] prod;

    always_comb begin
        w      = EXT_W'(1) << log2w;
        h      = EXT_W'(1) << log2h;
        lmin   = (log2w < log2h) ? log2w : log2h;
        diff   = (log2w > log2h) ? (log2w - log2h) : (log2h - log2w);
        rnd    = '0;
        shamt  = '0;
        prod   = '0;
        case (mode)
            DC_LEFT: begin
                rnd   = h >> 1;
                shamt = log2h;
            end
            DC_ABOVE: begin
                rnd   = w >> 1;
                shamt = log2w;
            end
            DC_BOTH: begin
                if (diff == 3'd0) begin
                    rnd   = w;
                    shamt = log2w + 3'd1;
                end else begin
                    rnd   = (w + h) >> 1;
                    shamt = lmin;
                end
            end
            default: ;
        endcase
        acc    = EXT_W'(sum) + rnd;
        s      = acc >> shamt;
        dc_raw = s;
        if (mode == DC_BOTH && diff != 3'd0) begin
            prod   = PROD_W'(s) * PROD_W'((diff == 3'd2) ? RECIP_R4 : RECIP_R2);
            dc_raw = EXT_W'(prod >> 16);
        end
        if (mode == DC_NONE) begin
            dc_raw = EXT_W'(1) << (BIT_DEPTH - 1);
        end
        dc = (dc_raw > DC_MAX) ? DC_MAX[BIT_DEPTH-1:0] : dc_raw[BIT_DEPTH-1:0];
    end

endmodule

// File: rtl/dc_pred_engine.sv
// Streaming AV1 DC intra predictor: takes a block config, accumulates above/left
// neighbours, then emits the DC-filled block row-major, LANES pixels per beat.
module dc_pred_engine
    import av1_pred_pkg::*;
#(
    parameter int BIT_DEPTH = 10,
    parameter int NUM_CH    = 3,
    parameter int LANES     = 4,
    parameter int MAX_LOG2  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [2:0]                        cfg_log2w,
    input  logic [2:0]                        cfg_log2h,
    input  logic                              cfg_left,
    input  logic                              cfg_above,
    output logic                              cfg_err,
    input  logic                              nbr_valid,
    output logic                              nbr_ready,
    input  logic [LANES*NUM_CH*BIT_DEPTH-1:0] nbr_data,
    output logic                              pred_valid,
    input  logic                              pred_ready,
    output logic [LANES*NUM_CH*BIT_DEPTH-1:0] pred_data,
    output logic                              pred_last
);

    localparam int SUM_W     = BIT_DEPTH + MAX_LOG2 + 1;
    localparam int CNT_W     = 2 * MAX_LOG2 + 1;
    localparam int LANE_LOG2 = $clog2(LANES);

    dc_state_e                          state_q, state_d;
    logic [2:0]                         log2w_q, log2w_d, log2h_q, log2h_d;
    logic                               left_q, left_d, above_q, above_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_CH-1:0][SUM_W-1:0]       sum_q, sum_d;
    logic [NUM_CH-1:0][BIT_DEPTH-1:0]   dc_q, dc_d;
    logic                               cfg_err_q, cfg_err_d;
    logic [BIT_DEPTH-1:0]               norm_dc [NUM_CH];

    logic             cfg_fire, nbr_fire, pred_fire, cfg_bad;
    logic [2:0]       cfg_diff, acc_sh;
    logic [3:0]       emit_sh;
    logic [CNT_W-1:0] acc_last, emit_last;
    dc_mode_e         mode;

    assign mode = dc_mode_e'({above_q, left_q});

    for (genvar c = 0; c < NUM_CH; c++) begin : g_norm
        dc_norm #(
            .BIT_DEPTH(BIT_DEPTH),
            .MAX_LOG2 (MAX_LOG2),
            .SUM_W    (SUM_W)
        ) u_norm (
            .sum  (sum_q[c]),
            .log2w(log2w_q),
            .log2h(log2h_q),
            .mode (mode),
            .dc   (norm_dc[c])
        );
    end

    assign cfg_ready  = (state_q == ST_IDLE) && rst_n;
    assign nbr_ready  = (state_q == ST_ACC_ABOVE) || (state_q == ST_ACC_LEFT);
    assign pred_valid = (state_q == ST_EMIT);
    assign pred_last  = pred_valid && (cnt_q == emit_last);
    assign pred_data  = {LANES{dc_q}};
    assign cfg_err    = cfg_err_q;

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign nbr_fire  = nbr_valid && nbr_ready;
    assign pred_fire = pred_valid && pred_ready;

    always_comb begin
        cfg_diff  = (cfg_log2w > cfg_log2h) ? (cfg_log2w - cfg_log2h) : (cfg_log2h - cfg_log2w);
        cfg_bad   = (cfg_log2w < 3'd2) || (cfg_log2h < 3'd2) ||
                    (cfg_log2w > 3'(MAX_LOG2)) || (cfg_log2h > 3'(MAX_LOG2)) ||
                    (cfg_diff > 3'd2);
        // Beat counts are powers of two, so the terminal counts are masks.
        acc_sh    = ((state_q == ST_ACC_ABOVE) ? log2w_q : log2h_q) - 3'(LANE_LOG2);
        acc_last  = (CNT_W'(1) << acc_sh) - CNT_W'(1);
        emit_sh   = {1'b0, log2w_q} + {1'b0, log2h_q} - 4'(LANE_LOG2);
        emit_last = (CNT_W'(1) << emit_sh) - CNT_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        log2w_d   = log2w_q;
        log2h_d   = log2h_q;
        left_d    = left_q;
        above_d   = above_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        dc_d      = dc_q;
        cfg_err_d = 1'b0;

        if (nbr_fire) begin
            for (int l = 0; l < LANES; l++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    sum_d[c] = sum_d[c] + SUM_W'(nbr_data[(l*NUM_CH+c)*BIT_DEPTH +: BIT_DEPTH]);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    sum_d = '0;
                    cnt_d = '0;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        log2w_d = cfg_log2w;
                        log2h_d = cfg_log2h;
                        left_d  = cfg_left;
                        above_d = cfg_above;
                        state_d = cfg_above ? ST_ACC_ABOVE :
                                  cfg_left  ? ST_ACC_LEFT  : ST_CALC;
                    end
                end
            end
            ST_ACC_ABOVE, ST_ACC_LEFT: begin
                if (nbr_fire) begin
                    if (cnt_q == acc_last) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_ACC_ABOVE && left_q) ? ST_ACC_LEFT : ST_CALC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CALC: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    dc_d[c] = norm_dc[c];
                end
                cnt_d   = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (pred_fire) begin
                    if (cnt_q == emit_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            log2w_q   <= 3'd2;
            log2h_q   <= 3'd2;
            left_q    <= 1'b0;
            above_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            dc_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            log2w_q   <= log2w_d;
            log2h_q   <= log2h_d;
            left_q    <= left_d;
            above_q   <= above_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            dc_q      <= dc_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_dc_pred_engine.sv
// Directed bench for dc_pred_engine with hand-computed DC values, built at MAX_LOG2=6.
module tb_dc_pred_engine;

    localparam int BW = 4 * 3 * 10;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_log2w;
    logic [2:0]    cfg_log2h;
    logic          cfg_left;
    logic          cfg_above;
    logic          cfg_err;
    logic          nbr_valid;
    logic          nbr_ready;
    logic [BW-1:0] nbr_data;
    logic          pred_valid;
    logic          pred_ready;
    logic [BW-1:0] pred_data;
    logic          pred_last;

    int checks = 0;
    int errors = 0;

    dc_pred_engine #(
        .BIT_DEPTH(10),
        .NUM_CH   (3),
        .LANES    (4),
        .MAX_LOG2 (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_log2w (cfg_log2w),
        .cfg_log2h (cfg_log2h),
        .cfg_left  (cfg_left),
        .cfg_above (cfg_above),
        .cfg_err   (cfg_err),
        .nbr_valid (nbr_valid),
        .nbr_ready (nbr_ready),
        .nbr_data  (nbr_data),
        .pred_valid(pred_valid),
        .pred_ready(pred_ready),
        .pred_data (pred_data),
        .pred_last (pred_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] pix(input logic [9:0] y, input logic [9:0] u, input logic [9:0] v);
        return {v, u, y};
    endfunction

    function automatic logic [BW-1:0] uni_beat(input logic [9:0] y, input logic [9:0] u, input logic [9:0] v);
        return {4{v, u, y}};
    endfunction

    task automatic send_cfg(input logic [2:0] lw, input logic [2:0] lh, input logic l, input logic a);
        int n;
        n = 0;
        @(negedge clk);
        cfg_log2w = lw;
        cfg_log2h = lh;
        cfg_left  = l;
        cfg_above = a;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_handshake got cfg_ready=%b want 1", cfg_ready);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic send_nbr(input logic [BW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        nbr_data  = d;
        nbr_valid = 1'b1;
        while (nbr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (nbr_ready !== 1'b1) begin
            errors++;
            $display("FAIL nbr_handshake got nbr_ready=%b want 1", nbr_ready);
        end
        @(posedge clk);
        #1 nbr_valid = 1'b0;
    endtask

    task automatic recv_block(input string name, input int nbeats, input logic [29:0] exp_pix,
                              input bit rand_ready, output int first_cyc);
        int            got;
        int            cyc;
        logic          held_v;
        logic [BW-1:0] held_d;
        logic          held_l;
        logic [BW-1:0] exp_d;
        logic          exp_l;
        got       = 0;
        cyc       = 0;
        held_v    = 1'b0;
        held_d    = '0;
        held_l    = 1'b0;
        first_cyc = -1;
        exp_d     = {4{exp_pix}};
        while (got < nbeats && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (held_v) begin
                checks++;
                if (pred_valid !== 1'b1 || pred_data !== held_d || pred_last !== held_l) begin
                    errors++;
                    $display("FAIL %s_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             name, pred_valid, pred_data, pred_last, held_d, held_l);
                end
            end
            if (!rand_ready && got > 0) begin
                checks++;
                if (pred_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_bubble beat %0d got pred_valid=%b want 1", name, got, pred_valid);
                end
            end
            pred_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pred_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            held_v = (pred_valid === 1'b1) && !pred_ready;
            held_d = pred_data;
            held_l = pred_last;
            if (pred_valid === 1'b1 && pred_ready) begin
                got++;
                exp_l = (got == nbeats);
                checks++;
                if (pred_data !== exp_d) begin
                    errors++;
                    $display("FAIL %s_data beat %0d got %h want %h", name, got, pred_data, exp_d);
                end
                checks++;
                if (pred_last !== exp_l) begin
                    errors++;
                    $display("FAIL %s_last beat %0d got %b want %b", name, got, pred_last, exp_l);
                end
            end
        end
        checks++;
        if (got != nbeats) begin
            errors++;
            $display("FAIL %s_count got %0d beats want %0d", name, got, nbeats);
        end
        @(negedge clk);
        pred_ready = 1'b0;
        checks++;
        if (pred_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end got pred_valid=%b cfg_ready=%b want 0 1", name, pred_valid, cfg_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pred_valid !== 1'b0 || pred_data !== '0 || pred_last !== 1'b0 ||
            nbr_ready !== 1'b0 || cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got pv=%b pd=%h pl=%b nr=%b ce=%b cr=%b want all 0",
                     pred_valid, pred_data, pred_last, nbr_ready, cfg_err, cfg_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got cfg_ready=%b want 1", cfg_ready);
        end
    endtask

    task automatic test_no_nbr();
        int first;
        send_cfg(3'd2, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (pred_valid !== 1'b0 || nbr_ready !== 1'b0) begin
            errors++;
            $display("FAIL none_calc got pred_valid=%b nbr_ready=%b want 0 0", pred_valid, nbr_ready);
        end
        recv_block("none4x4", 4, pix(10'd512, 10'd512, 10'd512), 1'b0, first);
        checks++;
        if (first != 1) begin
            errors++;
            $display("FAIL none_latency got %0d want 1 cycle after calc", first);
        end
    endtask

    task automatic test_left_only();
        int first;
        send_cfg(3'd2, 3'd2, 1'b1, 1'b0);
        send_nbr({pix(10'd40, 10'd7, 10'd0), pix(10'd30, 10'd7, 10'd0),
                  pix(10'd20, 10'd7, 10'd0), pix(10'd10, 10'd7, 10'd0)});
        @(negedge clk);
        checks++;
        if (nbr_ready !== 1'b0) begin
            errors++;
            $display("FAIL left_nbr_count got nbr_ready=%b want 0 after 1 beat", nbr_ready);
        end
        recv_block("left4x4", 4, pix(10'd25, 10'd7, 10'd0), 1'b0, first);
    endtask

    task automatic test_both_square(input bit rand_ready);
        int first;
        send_cfg(3'd3, 3'd3, 1'b1, 1'b1);
        repeat (2) send_nbr(uni_beat(10'd100, 10'd0, 10'd1023));
        repeat (2) send_nbr(uni_beat(10'd200, 10'd0, 10'd1));
        @(negedge clk);
        checks++;
        if (nbr_ready !== 1'b0 || pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL both8x8_calc got nbr_ready=%b pred_valid=%b want 0 0", nbr_ready, pred_valid);
        end
        recv_block(rand_ready ? "stall8x8" : "both8x8", 16, pix(10'd150, 10'd0, 10'd512), rand_ready, first);
    endtask

    task automatic test_ratio();
        int first;
        send_cfg(3'd4, 3'd2, 1'b1, 1'b1);
        repeat (4) send_nbr(uni_beat(10'd100, 10'd0, 10'd0));
        send_nbr(uni_beat(10'd40, 10'd0, 10'd0));
        recv_block("ratio4_16x4", 16, pix(10'd88, 10'd0, 10'd0), 1'b0, first);
        send_cfg(3'd3, 3'd2, 1'b1, 1'b1);
        repeat (2) send_nbr(uni_beat(10'd100, 10'd0, 10'd0));
        send_nbr(uni_beat(10'd40, 10'd0, 10'd0));
        recv_block("ratio2_8x4", 8, pix(10'd80, 10'd0, 10'd0), 1'b0, first);
    endtask

    task automatic test_reset_emit();
        send_cfg(3'd2, 3'd2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pred_ready = 1'b0;
        checks++;
        if (pred_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_emit_entry got pred_valid=%b want 1", pred_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (pred_valid !== 1'b0 || cfg_ready !== 1'b0 || pred_data !== '0) begin
            errors++;
            $display("FAIL rst_emit_hold got pv=%b cr=%b pd=%h want 0 0 0", pred_valid, cfg_ready, pred_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pred_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_emit_release got pv=%b cr=%b want 0 1", pred_valid, cfg_ready);
        end
    endtask

    task automatic check_cfg_err(input string name, input logic [2:0] lw, input logic [2:0] lh);
        send_cfg(lw, lh, 1'b1, 1'b1);
        nbr_data  = uni_beat(10'd5, 10'd5, 10'd5);
        nbr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL %s_err_pulse got cfg_err=%b want 1", name, cfg_err);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_err_width got cfg_err=%b want 0", name, cfg_err);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (nbr_ready !== 1'b0 || pred_valid !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_idle got nr=%b pv=%b cr=%b want 0 0 1", name, nbr_ready, pred_valid, cfg_ready);
            end
        end
        nbr_valid = 1'b0;
    endtask

    task automatic test_cfg_err();
        int first;
        check_cfg_err("w64h4", 3'd6, 3'd2);
        check_cfg_err("w2", 3'd1, 3'd2);
        check_cfg_err("w128", 3'd7, 3'd6);
        send_cfg(3'd3, 3'd2, 1'b0, 1'b1);
        send_nbr(uni_beat(10'd50, 10'd0, 10'd1023));
        send_nbr(uni_beat(10'd60, 10'd0, 10'd1023));
        recv_block("above8x4", 8, pix(10'd55, 10'd0, 10'd1023), 1'b0, first);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_log2w  = 3'd2;
        cfg_log2h  = 3'd2;
        cfg_left   = 1'b0;
        cfg_above  = 1'b0;
        nbr_valid  = 1'b0;
        nbr_data   = '0;
        pred_ready = 1'b0;

        test_reset();
        test_no_nbr();
        test_left_only();
        test_both_square(1'b0);
        test_ratio();
        test_both_square(1'b1);
        test_reset_emit();
        test_cfg_err();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
